// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the 4-bit ALU and its BIST sequencer:
//               operand width, opcode encodings, sequencer states and the
//               bit-accurate ALU reference model.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int W = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_XNOR = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bist_state_e;

  // Expected ALU result; arithmetic wraps modulo 2**W, unused opcodes give 0.
  function automatic logic [W-1:0] alu_model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [3:0]   sel
  );
    logic [W-1:0] r;
    case (sel)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOTA: r = ~a;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_SHL:  r = a << 1;
      OP_SHR:  r = a >> 1;
      OP_INC:  r = a + {{(W-1){1'b0}}, 1'b1};
      OP_DEC:  r = a - {{(W-1){1'b0}}, 1'b1};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : alu_ref_model
// Description : Combinational wrapper around alu_pkg::alu_model so the same
//               reference can be dropped next to any ALU consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   sel,
  output logic [W-1:0] res
);

  // Pure function evaluation, no state.
  always_comb begin
    res = alu_model(a, b, sel);
  end

endmodule : alu_ref_model
`default_nettype wire

// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
// Module      : alu_bist
// Description : Built-in self-test sequencer for the 4-bit ALU. Sweeps the
//               opcodes with a captured operand pair, holds each opcode for
//               DWELL cycles, compares the ALU result against the reference
//               model and reports pass, mismatch count and first bad opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bist
  import alu_pkg::*;
#(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned NUM_OPS = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_seed,
  input  logic [W-1:0] b_seed,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [3:0]   sel,
  input  logic [W-1:0] res,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [3:0]   err_count,
  output logic         fail_valid,
  output logic [3:0]   fail_sel
);

  // Terminal values for the dwell counter and the opcode counter. Both
  // parameters top out at 16, so a 4-bit counter always covers the range.
  localparam logic [3:0] DWELL_LAST   = 4'(DWELL - 1);
  localparam logic [3:0] NUM_OPS_LAST = 4'(NUM_OPS - 1);

  bist_state_e  state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   sel_q, sel_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic [3:0]   err_q, err_d;
  logic         fv_q, fv_d;
  logic [3:0]   fsel_q, fsel_d;

  logic [W-1:0] w_model_res;
  logic         w_mismatch;
  logic [3:0]   w_err_inc;

  alu_ref_model u_ref (
    .a   (a_q),
    .b   (b_q),
    .sel (sel_q),
    .res (w_model_res)
  );

  // Mismatch flag and saturating increment of the error counter.
  always_comb begin
    w_mismatch = (res != w_model_res);
    w_err_inc  = (err_q == 4'hF) ? 4'hF : (err_q + 4'd1);
  end

  // Next-state logic for the sequencer and all result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fsel_d  = fsel_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a_seed;
          b_d     = b_seed;
          sel_d   = 4'd0;
          cnt_d   = 4'd0;
          err_d   = 4'd0;
          fv_d    = 1'b0;
          fsel_d  = 4'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      ST_RUN: begin
        // start is deliberately ignored here: a sweep always runs to the end.
        if (cnt_q != DWELL_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          if (w_mismatch) begin
            err_d = w_err_inc;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fsel_d = sel_q;
            end
          end
          if (sel_q != NUM_OPS_LAST) begin
            sel_d = sel_q + 4'd1;
            cnt_d = 4'd0;
          end else begin
            // Verdict is registered together with done, using the count
            // that includes this final sample.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 4'd0);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; asynchronous reset returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'd0;
      fv_q    <= 1'b0;
      fsel_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fsel_q  <= fsel_d;
    end
  end

  // All outputs come straight from flops.
  always_comb begin
    A          = a_q;
    B          = b_q;
    sel        = sel_q;
    busy       = busy_q;
    done       = done_q;
    pass       = pass_q;
    err_count  = err_q;
    fail_valid = fv_q;
    fail_sel   = fsel_q;
  end

endmodule : alu_bist
`default_nettype wire
